spi_reg_arbiter: RTL and testbench
==================================

SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width; bank depth = 2**ADDR_W.
REQ-002 SHALL have parameter REG_W, default 8, register data width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstb  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port we0  input  1  port-0 posted write strobe, one-cycle pulse from SPI peripheral.
REQ-007 SHALL have port addr0  input  ADDR_W  port-0 address, for write and read.
REQ-008 SHALL have port wdata0  input  REG_W  port-0 write data, valid with we0.
REQ-009 SHALL have port rdata0  output  REG_W  port-0 read data, combinational bank[addr0].
REQ-010 SHALL have port req1  input  1  port-1 request, held until ack1.
REQ-011 SHALL have port wr_rdn1  input  1  port-1 direction, 1 = write, 0 = read.
REQ-012 SHALL have port addr1  input  ADDR_W  port-1 address.
REQ-013 SHALL have port wdata1  input  REG_W  port-1 write data.
REQ-014 SHALL have port ack1  output  1  port-1 completion, one-cycle pulse.
REQ-015 SHALL have port rdata1  output  REG_W  port-1 read data, valid while ack1 high.
REQ-016 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-017 SHALL have port regs  output  REG_W*2**ADDR_W  flat bank contents, reg 0 in the LSBs.
REQ-018 SHALL have port status  output  8  {overflow, pending0, busy, last_grant, 4'b0}.

Function
REQ-019 SHALL have states IDLE and ACCESS, plus grant register gnt (0/1) and last_grant register.
REQ-020 SHALL capture each we0 pulse with ena=1 into a one-deep pending buffer (addr, data) and set pending0 on the next cycle.
REQ-021 SHALL, in IDLE with ena=1 and at least one candidate (pending0, req1), select a winner, load gnt, and enter ACCESS next cycle.
REQ-022 SHALL, with both candidates present, grant the port that is not last_grant.
REQ-023 SHALL spend exactly one cycle in ACCESS, then return to IDLE; bank throughput is one access per 2 cycles.
REQ-024 SHALL, in ACCESS with gnt=0, write the pending data to bank[pending addr] at the cycle end and clear pending0.
REQ-025 SHALL, in ACCESS with gnt=1, assert ack1 for that cycle and drive rdata1 = bank[addr1]; if wr_rdn1=1, write wdata1 at the cycle end.
REQ-026 SHALL update last_grant to gnt on leaving ACCESS.
REQ-027 SHALL treat a req1 deasserted in IDLE before grant as abandoned; once in ACCESS, the access completes.
REQ-028 SHALL capture a we0 pulse that arrives while pending0 drains in ACCESS (set wins over clear).
REQ-029 SHALL drop a we0 pulse that arrives while pending0=1 and not draining, and set overflow (sticky).
REQ-030 SHALL clear overflow on ovf_clr=1; if ovf_clr and a new overflow occur together, overflow stays set.
REQ-031 SHALL, when ena=0, hold state, gnt, pending, bank and overflow, ignore we0, and force ack1=0.
REQ-032 SHALL drive rdata0 and regs combinationally from the bank; both reflect a write on the cycle after it.

Reset
REQ-033 SHALL, on rstb=0 at a clock edge, regardless of ena or an in-flight access, set the bank to 0, state to IDLE, gnt to 0, last_grant to 1, and clear pending0, overflow and ack1.
REQ-034 SHALL give port 0 first grant after reset when both ports request.

Configuration
REQ-035 SHALL use macro SPI_ARB_ROUND_ROBIN_EN: defined gives round-robin per REQ-022; undefined gives fixed priority to port 0, and last_grant still updates for status.

Structure
REQ-036 SHALL place the state enum, port index constants (PORT_SPI=0, PORT_AUX=1) and the status bit-position constants in package spi_arb_pkg.
REQ-037 SHALL put the bank storage in sub-module spi_reg_bank: one write port, the combinational read port and the flat regs output.

Verification
REQ-038 SHALL cover: reset -> regs all 0, status = 8'h10, ack1 = 0.
REQ-039 SHALL cover: we0 pulse with addr0=3, wdata0=8'hA5 -> bank[3]=8'hA5 three cycles later; rdata0 = 8'hA5 with addr0=3.
REQ-040 SHALL cover: req1 write (addr1=5, 8'h3C) in the same cycle as we0 (addr 5, 8'hC3) -> port 0 first, then port 1; final bank[5]=8'h3C; with SPI_ARB_ROUND_ROBIN_EN undefined, the same order holds.
REQ-041 SHALL cover: two we0 pulses 1 cycle apart while port 1 holds the grant -> second write dropped, status[7]=1; ovf_clr -> status[7]=0.
REQ-042 SHALL cover: req1 read of addr 2 holding 8'h7E -> ack1 single pulse with rdata1=8'h7E, 2 cycles after req1 rises.
REQ-043 SHALL cover: ena=0 for 4 cycles mid-ACCESS -> no ack1, state held; ack1 fires the first cycle after ena returns.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI register-bank arbiter.
package spi_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam logic PORT_SPI = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Bit positions inside the status byte; the low nibble is always zero.
  localparam int ST_OVF  = 7;
  localparam int ST_PEND = 6;
  localparam int ST_BUSY = 5;
  localparam int ST_LAST = 4;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: one synchronous write port, one combinational read port and a flat view.
module spi_reg_bank #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                          clk_i,
  input  logic                          rstb_i,
  input  logic                          we_i,
  input  logic [ADDR_W-1:0]             waddr_i,
  input  logic [REG_W-1:0]              wdata_i,
  input  logic [ADDR_W-1:0]             raddr_i,
  output logic [REG_W-1:0]              rdata_o,
  output logic [REG_W*(2**ADDR_W)-1:0]  regs_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [REG_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_o[g*REG_W +: REG_W] = mem_q[g];
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Two-port arbiter in front of the register bank: posted SPI writes (port 0) vs. request/ack port 1.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module spi_reg_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ena,
  input  logic                          we0,
  input  logic [ADDR_W-1:0]             addr0,
  input  logic [REG_W-1:0]              wdata0,
  output logic [REG_W-1:0]              rdata0,
  input  logic                          req1,
  input  logic                          wr_rdn1,
  input  logic [ADDR_W-1:0]             addr1,
  input  logic [REG_W-1:0]              wdata1,
  output logic                          ack1,
  output logic [REG_W-1:0]              rdata1,
  input  logic                          ovf_clr,
  output logic [REG_W*(2**ADDR_W)-1:0]  regs,
  output logic [7:0]                    status
);

  arb_state_e        state_q;
  logic              gnt_q, lastGrant_q, ack1_q, req1_q;
  logic              pend_q, pend_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic [REG_W-1:0]  pendData_q, pendData_d;
  logic              cand0, cand1, winner, draining, newOvf;
  logic              bankWe;
  logic [ADDR_W-1:0] bankAddr;
  logic [REG_W-1:0]  bankData;

  // req1 is registered so it lines up with pending0, which also appears a cycle after its strobe.
  assign cand0    = pend_q;
  assign cand1    = req1_q & req1;
  assign draining = (state_q == ACCESS) && (gnt_q == PORT_SPI);

`ifdef SPI_ARB_ROUND_ROBIN_EN
  assign winner = (cand0 & cand1) ? ~lastGrant_q : cand1;
`else
  assign winner = cand1 & ~cand0;
`endif

  always_comb begin
    pend_d     = pend_q;
    pendAddr_d = pendAddr_q;
    pendData_d = pendData_q;
    newOvf     = 1'b0;
    if (draining) pend_d = 1'b0;
    if (we0) begin
      if (!pend_q || draining) begin
        pend_d     = 1'b1;
        pendAddr_d = addr0;
        pendData_d = wdata0;
      end else begin
        newOvf = 1'b1;
      end
    end
    ovf_d = newOvf | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      gnt_q       <= PORT_SPI;
      lastGrant_q <= PORT_AUX;
      ack1_q      <= 1'b0;
      req1_q      <= 1'b0;
      pend_q      <= 1'b0;
      pendAddr_q  <= '0;
      pendData_q  <= '0;
      ovf_q       <= 1'b0;
    end else if (ena) begin
      req1_q     <= req1 & ~((state_q == ACCESS) && (gnt_q == PORT_AUX));
      pend_q     <= pend_d;
      pendAddr_q <= pendAddr_d;
      pendData_q <= pendData_d;
      ovf_q      <= ovf_d;
      case (state_q)
        IDLE: begin
          if (cand0 | cand1) begin
            state_q <= ACCESS;
            gnt_q   <= winner;
            ack1_q  <= winner;
          end
        end
        ACCESS: begin
          state_q     <= IDLE;
          lastGrant_q <= gnt_q;
          ack1_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bankWe   = ena && (state_q == ACCESS) && ((gnt_q == PORT_SPI) || wr_rdn1);
  assign bankAddr = (gnt_q == PORT_AUX) ? addr1  : pendAddr_q;
  assign bankData = (gnt_q == PORT_AUX) ? wdata1 : pendData_q;

  spi_reg_bank #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_bank (
    .clk_i   (clk),
    .rstb_i  (rstb),
    .we_i    (bankWe),
    .waddr_i (bankAddr),
    .wdata_i (bankData),
    .raddr_i (addr0),
    .rdata_o (rdata0),
    .regs_o  (regs)
  );

  assign ack1   = ack1_q & ena;
  assign rdata1 = regs[addr1*REG_W +: REG_W];

  always_comb begin
    status          = '0;
    status[ST_OVF]  = ovf_q;
    status[ST_PEND] = pend_q;
    status[ST_BUSY] = (state_q == ACCESS);
    status[ST_LAST] = lastGrant_q;
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed self-checking bench for spi_reg_arbiter with hand-computed expectations.
module tb_spi_reg_arbiter;

  logic        clk = 1'b0;
  logic        rstb, ena, we0, req1, wr_rdn1, ovf_clr, ack1;
  logic [2:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1, rdata0, rdata1, status;
  logic [63:0] regs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_reg_arbiter #(.ADDR_W(3), .REG_W(8)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .rdata0  (rdata0),
    .req1    (req1),
    .wr_rdn1 (wr_rdn1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .ack1    (ack1),
    .rdata1  (rdata1),
    .ovf_clr (ovf_clr),
    .regs    (regs),
    .status  (status)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [7:0] d);
    we0    = w;
    addr0  = a;
    wdata0 = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, pulses;
    logic [7:0] rd;

    rstb = 1'b0; ena = 1'b1; ovf_clr = 1'b0;
    applyStimulus(1'b0, 3'd0, 8'h00);
    req1 = 1'b0; wr_rdn1 = 1'b0; addr1 = 3'd0; wdata1 = 8'h00;
    tick(); tick();
    rstb = 1'b1;
    #1;
    checkOutput("reset regs", regs, 64'h0);
    checkOutput("reset status", {56'h0, status}, 64'h10);
    checkOutput("reset ack1", {63'h0, ack1}, 64'h0);

    // Simultaneous port-0 write and port-1 write to addr 5: port 0 goes first.
    applyStimulus(1'b1, 3'd5, 8'hC3);
    req1 = 1'b1; wr_rdn1 = 1'b1; addr1 = 3'd5; wdata1 = 8'h3C;
    tick(); we0 = 1'b0;
    checkOutput("both: pending", {56'h0, status}, 64'h50);
    checkOutput("both: no ack yet", {63'h0, ack1}, 64'h0);
    tick();
    checkOutput("both: port0 access", {56'h0, status}, 64'h70);
    checkOutput("both: ack during port0", {63'h0, ack1}, 64'h0);
    checkOutput("both: bank5 before", {56'h0, regs[47:40]}, 64'h0);
    tick();
    checkOutput("both: port0 done", {56'h0, status}, 64'h00);
    checkOutput("both: bank5 = C3", {56'h0, rdata0}, 64'hC3);
    tick();
    checkOutput("both: port1 ack", {63'h0, ack1}, 64'h1);
    checkOutput("both: rdata1 old", {56'h0, rdata1}, 64'hC3);
    checkOutput("both: port1 access", {56'h0, status}, 64'h20);
    req1 = 1'b0;
    tick();
    checkOutput("both: ack cleared", {63'h0, ack1}, 64'h0);
    checkOutput("both: bank5 = 3C", {56'h0, rdata0}, 64'h3C);
    checkOutput("both: last grant 1", {56'h0, status}, 64'h10);

    // Posted write addr 3 lands three edges after the strobe.
    applyStimulus(1'b1, 3'd3, 8'hA5);
    tick(); we0 = 1'b0;
    #1;
    checkOutput("we0: pending", {56'h0, status}, 64'h50);
    checkOutput("we0: bank3 edge1", {56'h0, rdata0}, 64'h0);
    tick();
    checkOutput("we0: access", {56'h0, status}, 64'h70);
    checkOutput("we0: bank3 edge2", {56'h0, rdata0}, 64'h0);
    tick();
    checkOutput("we0: bank3 = A5", {56'h0, rdata0}, 64'hA5);
    checkOutput("we0: status idle", {56'h0, status}, 64'h00);
    checkOutput("we0: regs flat", regs, 64'h0000_3C00_A500_0000);

    // Port-1 read of addr 2 holding 7E.
    applyStimulus(1'b1, 3'd2, 8'h7E);
    tick(); we0 = 1'b0;
    tick(); tick();
    req1 = 1'b1; wr_rdn1 = 1'b0; addr1 = 3'd2;
    lat = -1; pulses = 0; rd = 8'h00;
    #1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      if (ack1 === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          rd  = rdata1;
        end
        req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    checkOutput("read: ack latency", 64'(lat), 64'd2);
    checkOutput("read: ack pulses", 64'(pulses), 64'd1);
    checkOutput("read: rdata1", {56'h0, rd}, 64'h7E);
    checkOutput("read: last grant", {56'h0, status}, 64'h10);

    // Overflow: two strobes on consecutive cycles while port 1 holds the grant.
    req1 = 1'b1; wr_rdn1 = 1'b0; addr1 = 3'd2;
    tick();
    applyStimulus(1'b1, 3'd6, 8'h11);
    tick();
    checkOutput("ovf: port1 granted", {63'h0, ack1}, 64'h1);
    checkOutput("ovf: first captured", {56'h0, status}, 64'h70);
    applyStimulus(1'b1, 3'd7, 8'h22);
    req1 = 1'b0;
    tick(); we0 = 1'b0;
    checkOutput("ovf: flag set", {56'h0, status}, 64'hD0);
    tick();
    checkOutput("ovf: drain access", {56'h0, status}, 64'hF0);
    applyStimulus(1'b1, 3'd1, 8'h33);
    tick(); we0 = 1'b0;
    checkOutput("ovf: set beats clear", {56'h0, status}, 64'hC0);
    checkOutput("ovf: bank6 written", {56'h0, regs[55:48]}, 64'h11);
    checkOutput("ovf: bank7 dropped", {56'h0, regs[63:56]}, 64'h0);
    tick(); tick();
    checkOutput("ovf: bank1 written", {56'h0, regs[15:8]}, 64'h33);
    checkOutput("ovf: sticky", {56'h0, status}, 64'h80);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    checkOutput("ovf: cleared", {56'h0, status}, 64'h00);

    // Freeze with ena=0 for four edges in the middle of a port-1 access.
    req1 = 1'b1; wr_rdn1 = 1'b0; addr1 = 3'd6;
    tick(); tick();
    ena = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'hFF);
    #1;
    checkOutput("freeze: ack forced 0", {63'h0, ack1}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      we0 = 1'b0;
      checkOutput("freeze: ack1 held", {63'h0, ack1}, 64'h0);
      checkOutput("freeze: state held", {56'h0, status}, 64'h20);
    end
    ena = 1'b1;
    #1;
    checkOutput("freeze: ack on resume", {63'h0, ack1}, 64'h1);
    checkOutput("freeze: rdata1", {56'h0, rdata1}, 64'h11);
    req1 = 1'b0;
    tick();
    checkOutput("freeze: ack done", {63'h0, ack1}, 64'h0);
    checkOutput("freeze: status idle", {56'h0, status}, 64'h10);
    checkOutput("freeze: we0 ignored", {56'h0, regs[7:0]}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
